// File: rtl/adder_arb_pkg.sv
// Shared constants, ID-width helper and pipeline stage record for adder_arbiter.
package adder_arb_pkg;
    localparam int DATA_W    = 8;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W_MAX  = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // The ID field is sized for the largest supported N_REQ (8).
    typedef struct packed {
        logic                vld;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [ID_W_MAX-1:0] id;
    } stage_t;
endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and result bus of adder_arbiter; sum_ovf exists only with ADDER_ARB_OVF_EN.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    // Handshakes: req[i] stays up with operands stable until gnt[i] pulses; that
    // pulse consumes one operand pair. A result moves on sum_vld & sum_rdy and
    // sum_out/sum_id hold while sum_vld=1 and sum_rdy=0.
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] a_in;
    logic [N_REQ*DATA_W-1:0] b_in;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       sum_out;
    logic [ID_W-1:0]         sum_id;
    logic                    sum_vld;
    logic                    sum_rdy;
    logic                    busy;
`ifdef ADDER_ARB_OVF_EN
    logic                    sum_ovf;

    modport master (output req, a_in, b_in, sum_rdy,
                    input  gnt, sum_out, sum_id, sum_vld, busy, sum_ovf);
    modport slave  (input  req, a_in, b_in, sum_rdy,
                    output gnt, sum_out, sum_id, sum_vld, busy, sum_ovf);
`else
    modport master (output req, a_in, b_in, sum_rdy,
                    input  gnt, sum_out, sum_id, sum_vld, busy);
    modport slave  (input  req, a_in, b_in, sum_rdy,
                    output gnt, sum_out, sum_id, sum_vld, busy);
`endif
endinterface

// File: rtl/adder.sv
// Team 8-bit ripple-carry adder: combinational, no carry-in, carry-out dropped.
module Adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s
);
    logic [7:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < 7) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first req at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);
    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (en && !found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin share of one Adder among N_REQ requesters, two register stages.
// Optional signed-overflow output sum_ovf is built when ADDER_ARB_OVF_EN is defined.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);
    if (ID_W != clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_cfg
        $error("adder_arbiter: N_REQ must be 2..8 and ID_W must equal clog2(N_REQ)");
    end

    stage_t            op_q, op_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              vld_q, vld_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic [DATA_W-1:0] add_sum;
    logic              adv2, acc1, any_gnt;

    assign adv2    = ~vld_q | bus.sum_rdy;
    assign acc1    = ~op_q.vld | adv2;
    assign any_gnt = |pick_gnt;

    // Gating with rst keeps gnt low for the whole reset, not just after the edge.
    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .en  (acc1 & ~rst),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    Adder u_adder (
        .a (op_q.a),
        .b (op_q.b),
        .s (add_sum)
    );

    always_comb begin
        op_d     = op_q;
        rr_ptr_d = rr_ptr_q;
        if (acc1) begin
            op_d.vld = any_gnt;
            if (any_gnt) begin
                op_d.a   = bus.a_in[int'(pick_idx)*DATA_W +: DATA_W];
                op_d.b   = bus.b_in[int'(pick_idx)*DATA_W +: DATA_W];
                op_d.id  = ID_W_MAX'(pick_idx);
                rr_ptr_d = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + ID_W'(1);
            end
        end
    end

    always_comb begin
        sum_d = sum_q;
        id_d  = id_q;
        vld_d = vld_q;
        if (adv2) begin
            sum_d = add_sum;
            id_d  = ID_W'(op_q.id);
            vld_d = op_q.vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            sum_q    <= '0;
            id_q     <= '0;
            vld_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            op_q     <= op_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
            vld_q    <= vld_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.gnt     = pick_gnt;
    assign bus.sum_out = sum_q;
    assign bus.sum_id  = id_q;
    assign bus.sum_vld = vld_q;
    assign bus.busy    = op_q.vld | vld_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    always_comb begin
        ovf_d = ovf_q;
        if (adv2) begin
            ovf_d = (op_q.a[DATA_W-1] == op_q.b[DATA_W-1]) &&
                    (add_sum[DATA_W-1] != op_q.a[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign bus.sum_ovf = ovf_q;
`endif
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one instance of the team's 8-bit ripple-carry adder (module Adder, combinational, no carry-in/out) among N_REQ requesters.
- Round-robin grant, req/gnt operand handshake, two-stage registered pipeline (operand regs -> Adder -> sum regs), result tagged with requester ID, valid/ready backpressure on the result.
- Sits between the math-function sequencers and the shared adder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(N_REQ), checked by elaboration-time assertion.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request; operands must be held stable while req=1 and gnt=0.
- a_in  in  N_REQ*8  packed operand A; requester i uses a_in[8i+7:8i].
- b_in  in  N_REQ*8  packed operand B, same packing.
- gnt  out  N_REQ  one-hot grant, combinational; operands are captured at the clock edge ending the gnt cycle.
- sum_out  out  8  registered sum, (a+b) mod 256.
- sum_id  out  ID_W  index of the requester that owns sum_out.
- sum_vld  out  1  result valid.
- sum_rdy  in  1  consumer accepts the result when sum_vld & sum_rdy.
- busy  out  1  op_vld | sum_vld.

Behaviour:
- Reset, asynchronous, any cycle including mid-operation:
  - op_vld=0, sum_vld=0, sum_out=0, sum_id=0, rr_ptr=0, gnt=0.
  - All in-flight operations are discarded with no partial result.
- Stage 2 (sum regs) advance: adv2 = ~sum_vld | sum_rdy. On adv2, sum_out<=Adder(op_a,op_b), sum_id<=op_id, sum_vld<=op_vld.
- Stage 1 (operand regs) accept: acc1 = ~op_vld | adv2. On acc1, op_vld<=|gnt; when a gnt is issued, op_a/op_b/op_id<=the winner's operands and index.
- Grant:
  - gnt is nonzero only when acc1=1 and |req=1.
  - Winner is the first asserted req at or after rr_ptr, searching upward with wrap from N_REQ-1 to 0.
  - On a grant to i, rr_ptr<=(i+1) mod N_REQ. Otherwise rr_ptr holds.
- Latency: gnt in cycle T -> sum_vld=1 in cycle T+2 when unstalled. Throughput is one add per cycle.
- Backpressure:
  - While sum_vld=1 and sum_rdy=0, sum_out and sum_id are held stable.
  - When op_vld is also 1, gnt=0 (pipeline full). If op_vld=0, one further grant is accepted, filling stage 1.
- A requester may hold req high after its gnt to issue back-to-back operations. Each gnt pulse consumes exactly one operand pair.
- Simultaneous requests from all N_REQ requesters give grants strictly in rotation. There is no starvation: worst-case wait is N_REQ-1 grants.
- req deasserted before gnt: the request is withdrawn, legal, and has no side effect.
- Arithmetic: sum is 8-bit modulo, and carry-out is discarded. The adder path is purely combinational between the two register stages.

Optional Feature:
- Macro ADDER_ARB_OVF_EN.
- Defined:
  - Extra output port sum_ovf (1 bit), registered alongside sum_out.
  - sum_ovf = signed overflow = (op_a[7]==op_b[7]) & (sum[7]!=op_a[7]).
  - Reset value 0; held under stall like sum_out.
- Undefined: the port is absent and there is no extra logic. All other behaviour is identical.

Decomposition:
- Package adder_arb_pkg:
  - DATA_W=8 constant.
  - Default N_REQ.
  - clog2 function used to derive ID_W.
  - Typedef for the stage record {vld, a, b, id}.
- One natural sub-module, rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req, rr_ptr, enable. Outputs: one-hot gnt, encoded index.
- Adder is instantiated once, unchanged.

Test Plan:
- Single add: reset; req[2]=1, a=0x3C, b=0x05 -> gnt=0100 in cycle T, sum_vld=1 with sum_out=0x41 and sum_id=2 in T+2.
- Wrap-around: a=0xFF, b=0x02 -> sum_out=0x01. With ADDER_ARB_OVF_EN: a=0x7F, b=0x01 -> sum_out=0x80, sum_ovf=1.
- Fairness: req=1111 held for 8 grants, sum_rdy=1 -> grant order 0,1,2,3,0,1,2,3; sum_id follows the same order two cycles later.
- Backpressure: sum_rdy=0 with req=1111 -> one result held stable, stage 1 fills, then gnt=0. Release sum_rdy -> results drain in order, grants resume with no loss or duplication.
- Reset mid-flight: assert rst while op_vld=1 and sum_vld=1 -> sum_vld=0, busy=0, gnt=0 immediately (asynchronous). After release, the first grant goes to requester 0 when req=1111.
- Withdrawn request: req[1] pulses for 1 cycle while stalled -> no gnt[1] and no result with sum_id=1.
